// File: rtl/sr_pulse_gen.sv
// Debounces two bouncing push-buttons and turns each debounced rising edge into a
// single-cycle s / r pulse for a downstream SR flip-flop; reset wins a tie.
module sr_pulse_gen #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_rst,
  output logic s,
  output logic r,
  output logic set_level,
  output logic rst_level,
  output logic conflict
);

  typedef enum logic [1:0] {LOW, RISE_CNT, HIGH, FALL_CNT} state_t;

  localparam logic [7:0] SC8 = 8'(STABLE_CYCLES);

  // Channel index 0 is the set button, index 1 the reset button.
  logic [1:0] raw;
  logic [1:0] sync1, sync2;
  logic [1:0] level, level_nxt;
  logic [1:0] rise;
  logic [7:0] cnt [2];
  logic [7:0] cnt_nxt [2];
  state_t     state [2];
  state_t     state_nxt [2];

  assign raw = {btn_rst, btn_set};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = 8'd0;
      level_nxt[i] = level[i];
      rise[i]      = 1'b0;
      // A count that reaches STABLE_CYCLES on this edge commits the new level.
      unique case (state[i])
        LOW: begin
          if (sync2[i]) begin
            if ((cnt[i] + 8'd1) == SC8) begin
              state_nxt[i] = HIGH;
              level_nxt[i] = 1'b1;
              rise[i]      = 1'b1;
            end else begin
              state_nxt[i] = RISE_CNT;
              cnt_nxt[i]   = cnt[i] + 8'd1;
            end
          end
        end
        RISE_CNT: begin
          if (!sync2[i]) begin
            state_nxt[i] = LOW;
          end else if ((cnt[i] + 8'd1) == SC8) begin
            state_nxt[i] = HIGH;
            level_nxt[i] = 1'b1;
            rise[i]      = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + 8'd1;
          end
        end
        HIGH: begin
          if (!sync2[i]) begin
            if ((cnt[i] + 8'd1) == SC8) begin
              state_nxt[i] = LOW;
              level_nxt[i] = 1'b0;
            end else begin
              state_nxt[i] = FALL_CNT;
              cnt_nxt[i]   = cnt[i] + 8'd1;
            end
          end
        end
        FALL_CNT: begin
          if (sync2[i]) begin
            state_nxt[i] = HIGH;
          end else if ((cnt[i] + 8'd1) == SC8) begin
            state_nxt[i] = LOW;
            level_nxt[i] = 1'b0;
          end else begin
            cnt_nxt[i] = cnt[i] + 8'd1;
          end
        end
        default: begin
          state_nxt[i] = LOW;
          level_nxt[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      level     <= 2'b00;
      state[0]  <= LOW;
      state[1]  <= LOW;
      cnt[0]    <= 8'd0;
      cnt[1]    <= 8'd0;
      s         <= 1'b0;
      r         <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      level     <= level_nxt;
      state[0]  <= state_nxt[0];
      state[1]  <= state_nxt[1];
      cnt[0]    <= cnt_nxt[0];
      cnt[1]    <= cnt_nxt[1];
      // Reset channel has priority so s and r are never high together.
      s         <= rise[0] & ~rise[1];
      r         <= rise[1];
      conflict  <= rise[0] & rise[1];
    end
  end

  assign set_level = level[0];
  assign rst_level = level[1];

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen: two instances (STABLE_CYCLES=4 and 1) share
// directed and random bouncing stimulus; a reference model predicts every cycle.
module tb_sr_pulse_gen;

  logic clk = 1'b0;
  logic rst, btn_set, btn_rst;
  logic s4, r4, c4, sl4, rl4;
  logic s1, r1, c1, sl1, rl1;

  always #5 clk = ~clk;

  sr_pulse_gen #(.STABLE_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_rst(btn_rst),
    .s(s4), .r(r4), .set_level(sl4), .rst_level(rl4), .conflict(c4)
  );

  sr_pulse_gen #(.STABLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_rst(btn_rst),
    .s(s1), .r(r1), .set_level(sl1), .rst_level(rl1), .conflict(c1)
  );

  // Expected vector: {q, conflict, r, s, rst_level, set_level}
  typedef logic [5:0] exp_t;
  exp_t exp4[$];
  exp_t exp1[$];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, indexed [cfg][channel]; cfg 0 -> SC=4, cfg 1 -> SC=1.
  int m_sc [2] = '{4, 1};
  bit m_d1 [2][2];
  bit m_d2 [2][2];
  bit m_stable [2][2];
  int m_run [2][2];
  bit m_q [2];
  bit dut_q [2];

  function automatic void model_reset(int c);
    for (int ch = 0; ch < 2; ch++) begin
      m_d1[c][ch] = 1'b0;
      m_d2[c][ch] = 1'b0;
      m_stable[c][ch] = 1'b0;
      m_run[c][ch] = 0;
    end
  endfunction

  // One clock edge: a level is accepted once the twice-delayed input has
  // disagreed with it for SC consecutive edges; acceptance of a 1 is an event.
  function automatic exp_t model_edge(int c, bit bs, bit br);
    bit raw [2];
    bit ev [2];
    bit ps, pr, pc;
    raw[0] = bs;
    raw[1] = br;
    for (int ch = 0; ch < 2; ch++) begin
      ev[ch] = 1'b0;
      if (m_d2[c][ch] != m_stable[c][ch]) begin
        m_run[c][ch]++;
        if (m_run[c][ch] >= m_sc[c]) begin
          m_stable[c][ch] = m_d2[c][ch];
          m_run[c][ch] = 0;
          ev[ch] = m_d2[c][ch];
        end
      end else begin
        m_run[c][ch] = 0;
      end
      m_d2[c][ch] = m_d1[c][ch];
      m_d1[c][ch] = raw[ch];
    end
    pr = ev[1];
    ps = ev[0] && !ev[1];
    pc = ev[0] && ev[1];
    if (pr) m_q[c] = 1'b0;
    else if (ps) m_q[c] = 1'b1;
    return {m_q[c], pc, pr, ps, m_stable[c][1], m_stable[c][0]};
  endfunction

  function automatic void check(string name, exp_t got, exp_t want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s at %0t: got {q,conf,r,s,rl,sl}=%b required %b", name, $time, got, want);
    end
  endfunction

  task automatic step(bit bs, bit br, bit rv);
    @(negedge clk);
    rst = rv;
    btn_set = bs;
    btn_rst = br;
    if (rv) begin
      for (int c = 0; c < 2; c++) model_reset(c);
      exp4.push_back({m_q[0], 5'b0});
      exp1.push_back({m_q[1], 5'b0});
      #1;
      check("async_reset_sc4", {1'b0, c4, r4, s4, rl4, sl4}, 6'b0);
      check("async_reset_sc1", {1'b0, c1, r1, s1, rl1, sl1}, 6'b0);
    end else begin
      exp4.push_back(model_edge(0, bs, br));
      exp1.push_back(model_edge(1, bs, br));
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare against the queue.
  initial begin
    exp_t e;
    dut_q[0] = 1'b0;
    dut_q[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (r4) dut_q[0] = 1'b0; else if (s4) dut_q[0] = 1'b1;
      if (r1) dut_q[1] = 1'b0; else if (s1) dut_q[1] = 1'b1;
      if (exp4.size() > 0) begin
        e = exp4.pop_front();
        check("sc4", {dut_q[0], c4, r4, s4, rl4, sl4}, e);
      end
      if (exp1.size() > 0) begin
        e = exp1.pop_front();
        check("sc1", {dut_q[1], c1, r1, s1, rl1, sl1}, e);
      end
    end
  end

  initial begin
    bit lvl_s, lvl_r, bs, br;
    int len;
    m_q[0] = 1'b0;
    m_q[1] = 1'b0;
    for (int c = 0; c < 2; c++) model_reset(c);
    rst = 1'b1;
    btn_set = 1'b0;
    btn_rst = 1'b0;
    repeat (3) step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    // Clean set press held
    repeat (20) step(1, 0, 0);
    repeat (10) step(0, 0, 0);
    // Bouncing reset press then held
    step(0, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
    repeat (12) step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    // Simultaneous presses
    repeat (10) step(1, 1, 0);
    repeat (10) step(0, 0, 0);
    // Reset mid-count with set held
    repeat (4) step(1, 0, 0);
    repeat (2) step(1, 0, 1);
    repeat (12) step(1, 0, 0);
    repeat (10) step(0, 0, 0);
    // Press, release, press again
    repeat (10) step(1, 0, 0);
    repeat (10) step(0, 0, 0);
    repeat (10) step(1, 0, 0);
    repeat (10) step(0, 0, 0);
    // Set then reset: downstream q 1 then 0
    repeat (10) step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    repeat (10) step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    // Random bouncing segments
    for (int seg = 0; seg < 300; seg++) begin
      lvl_s = 1'($urandom_range(0, 1));
      lvl_r = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 15);
      if ($urandom_range(0, 99) < 2) begin
        repeat ($urandom_range(1, 3)) step(lvl_s, lvl_r, 1);
      end
      for (int k = 0; k < len; k++) begin
        bs = ($urandom_range(0, 5) == 0) ? !lvl_s : lvl_s;
        br = ($urandom_range(0, 5) == 0) ? !lvl_r : lvl_r;
        step(bs, br, 0);
      end
    end
    repeat (10) step(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (exp4.size() != 0 || exp1.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d/%0d pending required 0", exp4.size(), exp1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
